// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, trap/jump redirects,
// ready/stall handshake and a saturating accepted-fetch counter.
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              pc_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              ce_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] StepInc   = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, target;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid, accepted, redirect;

  always_comb begin
    valid    = (state_q == StRun);
    accepted = valid && pc_ready_i && !stall_i;
    // Redirects are not honoured during the single BOOT cycle.
    redirect = (trap_i || jump_i) && (state_q != StBoot);
    target   = trap_i ? trap_addr_i : jump_addr_i;

    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;

    if (redirect) begin
      // Abandoned request in this cycle is dropped, so the counter is left alone.
      state_d = StRun;
      pc_d    = target & AlignMask;
      mis_d   = |(target & ~AlignMask);
    end else begin
      unique case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (accepted) begin
            pc_d = pc_q + StepInc;
            if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
          end
          if (halt_i) state_d = StHalt;
        end
        StHalt: state_d = StHalt;
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StBoot;
      pc_q    <= RESET_ADDR;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid;
  assign ce_o        = valid;
  assign misalign_o  = mis_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32: width of the program counter in bits.
REQ-002 SHALL provide parameter RESET_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL provide parameter STEP, default 4: sequential byte increment; legal values 2, 4, 8.
REQ-004 SHALL provide parameter CNT_W, default 16: width of the fetch counter.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL provide port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 SHALL provide port rst_i, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL provide port stall_i, input, 1 bit: pipeline stall; hold the current PC.
REQ-009 SHALL provide port halt_i, input, 1 bit: stop fetching until the next redirect.
REQ-010 SHALL provide port jump_i, input, 1 bit: branch/jump redirect request.
REQ-011 SHALL provide port jump_addr_i, input, ADDR_W bits: branch/jump target.
REQ-012 SHALL provide port trap_i, input, 1 bit: trap redirect request.
REQ-013 SHALL provide port trap_addr_i, input, ADDR_W bits: trap vector.
REQ-014 SHALL provide port pc_ready_i, input, 1 bit: instruction memory accepts the current request.
REQ-015 SHALL provide port pc_o, output, ADDR_W bits: fetch address.
REQ-016 SHALL provide port pc_valid_o, output, 1 bit: pc_o is a valid fetch request.
REQ-017 SHALL provide port ce_o, output, 1 bit: instruction memory chip enable; equals pc_valid_o.
REQ-018 SHALL provide port misalign_o, output, 1 bit: one-cycle pulse when an accepted redirect target had nonzero bits [log2(STEP)-1:0].
REQ-019 SHALL provide port fetch_cnt_o, output, CNT_W bits: count of accepted fetches.

Function
REQ-020 SHALL implement states BOOT, RUN and HALT.
REQ-021 SHALL stay in BOOT for exactly one cycle after reset release, with pc_o=RESET_ADDR and pc_valid_o=0, then enter RUN.
REQ-022 SHALL drive pc_valid_o=1 in RUN and pc_valid_o=0 in BOOT and HALT.
REQ-023 SHALL treat a fetch as accepted when pc_valid_o && pc_ready_i && !stall_i in the same cycle.
REQ-024 SHALL apply next-PC priority trap_i > jump_i > halt_i > hold (stall_i, or !pc_ready_i) > sequential.
REQ-025 SHALL load trap_addr_i or jump_addr_i, with the low log2(STEP) bits forced to zero, on the edge where the redirect is sampled, in any state except BOOT.
REQ-026 SHALL take redirect effect regardless of pc_ready_i or stall_i; the abandoned request is dropped and not counted.
REQ-027 SHALL enter RUN from HALT or RUN on any redirect.
REQ-028 SHALL ignore redirects sampled during BOOT.
REQ-029 SHALL, on an accepted fetch with no redirect, set pc_o <= pc_o + STEP, modulo 2^ADDR_W (all-ones region wraps to 0, no flag).
REQ-030 SHALL keep pc_o and pc_valid_o stable while valid && !(ready && !stall) and no redirect is present.
REQ-031 SHALL, when halt_i is sampled in RUN with no redirect, enter HALT: PC advances if the fetch in that cycle was accepted, otherwise holds.
REQ-032 SHALL pulse misalign_o for one cycle, coincident with the new pc_o, after a misaligned redirect.
REQ-033 SHALL increment fetch_cnt_o by 1 per accepted fetch, saturating at 2^CNT_W-1.

Reset
REQ-034 SHALL, while rst_i=0, immediately force state=BOOT, pc_o=RESET_ADDR, pc_valid_o=0, ce_o=0, misalign_o=0, fetch_cnt_o=0, regardless of the clock.
REQ-035 SHALL, on reset assertion mid-operation (including mid-redirect or in HALT), discard all pending state; the BOOT/RUN sequence restarts on release.

Verification
REQ-036 Reset release with pc_ready_i=1, no other inputs: cycle 0 valid=0; then pc_o=0,4,8,C with valid=1; fetch_cnt_o=1,2,3.
REQ-037 pc_ready_i low for 3 cycles at pc_o=8: pc_o holds 8 with valid=1; count unchanged; resumes 8 -> C.
REQ-038 jump_i=1 with jump_addr_i=0x103 while stall_i=1: next pc_o=0x100, misalign_o=1 for one cycle, count unchanged.
REQ-039 trap_i and jump_i both asserted, trap_addr_i=0x80, jump_addr_i=0x200: next pc_o=0x80; with halt_i asserted in the same cycle, state=RUN.
REQ-040 halt_i at pc_o=0x10 (accepted): next pc_o=0x14, valid=0; stays until jump_i to 0x40; then pc_o=0x40, valid=1.
REQ-041 ADDR_W=8, STEP=4, pc_o=0xFC accepted: next pc_o=0x00; CNT_W=2 counter saturates at 3.
REQ-042 rst_i asserted asynchronously between clock edges while in RUN at pc_o=0x24: pc_o=RESET_ADDR and valid=0 before the next edge.
